// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX/MEM and MEM/WB forwarding, load-use detection and a bubble counter.
module id_ex_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int REG_ADDR_W    = 5,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     id_valid,
    input  logic [REG_ADDR_W-1:0]    id_rs1,
    input  logic [REG_ADDR_W-1:0]    id_rs2,
    input  logic [REG_ADDR_W-1:0]    id_rd,
    input  logic [DATA_WIDTH-1:0]    id_rs1_data,
    input  logic [DATA_WIDTH-1:0]    id_rs2_data,
    input  logic [DATA_WIDTH-1:0]    id_imm,
    input  logic                     id_alu_src,
    input  logic [OPCODE_LENGTH-1:0] id_alu_op,
    input  logic                     id_mem_read,
    input  logic                     id_mem_write,
    input  logic                     id_reg_write,
    input  logic                     flush,
    input  logic                     exmem_reg_write,
    input  logic [REG_ADDR_W-1:0]    exmem_rd,
    input  logic [DATA_WIDTH-1:0]    exmem_result,
    input  logic                     memwb_reg_write,
    input  logic [REG_ADDR_W-1:0]    memwb_rd,
    input  logic [DATA_WIDTH-1:0]    memwb_result,
    output logic                     load_use_stall,
    output logic                     ex_valid,
    output logic [DATA_WIDTH-1:0]    ex_src_a,
    output logic [DATA_WIDTH-1:0]    ex_src_b,
    output logic [OPCODE_LENGTH-1:0] ex_operation,
    output logic [DATA_WIDTH-1:0]    ex_store_data,
    output logic [REG_ADDR_W-1:0]    ex_rd,
    output logic                     ex_reg_write,
    output logic                     ex_mem_read,
    output logic                     ex_mem_write,
    output logic [CNT_W-1:0]         bubble_count
);
    logic                     valid_q, alu_src_q, mem_read_q, mem_write_q, reg_write_q;
    logic [REG_ADDR_W-1:0]    rs1_q, rs2_q, rd_q;
    logic [DATA_WIDTH-1:0]    rs1_data_q, rs2_data_q, imm_q, fwd_a, fwd_b;
    logic [OPCODE_LENGTH-1:0] alu_op_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     bubble, counted;

    // rs2 is compared even for immediate-form instructions; a spurious stall is harmless
    assign load_use_stall = id_valid & valid_q & mem_read_q & (rd_q != '0) &
                            ((rd_q == id_rs1) | (rd_q == id_rs2));
    assign counted = flush | load_use_stall;
    assign bubble  = counted | ~id_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            alu_src_q   <= 1'b0;
            alu_op_q    <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            reg_write_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            valid_q     <= ~bubble;
            mem_read_q  <= ~bubble & id_mem_read;
            mem_write_q <= ~bubble & id_mem_write;
            reg_write_q <= ~bubble & id_reg_write;
            if (!bubble) begin
                rs1_q      <= id_rs1;
                rs2_q      <= id_rs2;
                rd_q       <= id_rd;
                rs1_data_q <= id_rs1_data;
                rs2_data_q <= id_rs2_data;
                imm_q      <= id_imm;
                alu_src_q  <= id_alu_src;
                alu_op_q   <= id_alu_op;
            end
            if (counted && cnt_q != {CNT_W{1'b1}}) cnt_q <= cnt_q + 1'b1;
        end
    end

    // EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded
    always_comb begin
        fwd_a = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs1_q) ? exmem_result :
                (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs1_q) ? memwb_result : rs1_data_q;
        fwd_b = (exmem_reg_write && exmem_rd != '0 && exmem_rd == rs2_q) ? exmem_result :
                (memwb_reg_write && memwb_rd != '0 && memwb_rd == rs2_q) ? memwb_result : rs2_data_q;
    end

    assign ex_valid      = valid_q;
    assign ex_src_a      = fwd_a;
    assign ex_src_b      = alu_src_q ? imm_q : fwd_b;
    assign ex_store_data = fwd_b;
    assign ex_operation  = alu_op_q;
    assign ex_rd         = rd_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;
    assign bubble_count  = cnt_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and random checks of id_ex_stage against a transaction-level model.
module tb_id_ex_stage;
    localparam int CW = 4;

    logic clk = 1'b0, reset_n = 1'b0;
    logic id_valid = 0, id_alu_src = 0, id_mem_read = 0, id_mem_write = 0, id_reg_write = 0, flush = 0;
    logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0, exmem_rd = 0, memwb_rd = 0;
    logic [31:0] id_rs1_data = 0, id_rs2_data = 0, id_imm = 0, exmem_result = 0, memwb_result = 0;
    logic [3:0] id_alu_op = 0;
    logic exmem_reg_write = 0, memwb_reg_write = 0;
    logic load_use_stall, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic [31:0] ex_src_a, ex_src_b, ex_store_data;
    logic [3:0] ex_operation;
    logic [4:0] ex_rd;
    logic [CW-1:0] bubble_count;

    int checks = 0, failures = 0;

    typedef struct packed {
        logic v, src, mr, mw, rw;
        logic [4:0] rs1, rs2, rd;
        logic [31:0] d1, d2, imm;
        logic [3:0] op;
    } ex_t;
    ex_t m;
    int cnt_m;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .REG_ADDR_W(5), .CNT_W(CW)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_src(id_alu_src), .id_alu_op(id_alu_op), .id_mem_read(id_mem_read),
        .id_mem_write(id_mem_write), .id_reg_write(id_reg_write), .flush(flush),
        .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .load_use_stall(load_use_stall), .ex_valid(ex_valid), .ex_src_a(ex_src_a),
        .ex_src_b(ex_src_b), .ex_operation(ex_operation), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
        .ex_mem_write(ex_mem_write), .bubble_count(bubble_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [4:0] r, input logic [31:0] d);
        if (exmem_reg_write && exmem_rd != 0 && exmem_rd == r) return exmem_result;
        if (memwb_reg_write && memwb_rd != 0 && memwb_rd == r) return memwb_result;
        return d;
    endfunction

    function automatic logic exp_lus();
        return id_valid && m.v && m.mr && m.rd != 0 && (m.rd == id_rs1 || m.rd == id_rs2);
    endfunction

    task automatic check_ex();
        #1;
        chk("ex_valid", 32'(ex_valid), 32'(m.v));
        chk("ex_reg_write", 32'(ex_reg_write), 32'(m.rw));
        chk("ex_mem_read", 32'(ex_mem_read), 32'(m.mr));
        chk("ex_mem_write", 32'(ex_mem_write), 32'(m.mw));
        chk("bubble_count", 32'(bubble_count), 32'(cnt_m));
        if (m.v) begin
            chk("ex_src_a", ex_src_a, fwd(m.rs1, m.d1));
            chk("ex_src_b", ex_src_b, m.src ? m.imm : fwd(m.rs2, m.d2));
            chk("ex_store_data", ex_store_data, fwd(m.rs2, m.d2));
            chk("ex_operation", 32'(ex_operation), 32'(m.op));
            chk("ex_rd", 32'(ex_rd), 32'(m.rd));
        end
    endtask

    task automatic tick();
        logic lus;
        #1;
        lus = exp_lus();
        chk("load_use_stall", 32'(load_use_stall), 32'(lus));
        @(posedge clk);
        if (flush || lus) cnt_m = (cnt_m == (1 << CW) - 1) ? cnt_m : cnt_m + 1;
        if (flush || lus || !id_valid) begin
            m.v = 0; m.rw = 0; m.mr = 0; m.mw = 0;
        end else begin
            m.v = 1; m.rs1 = id_rs1; m.rs2 = id_rs2; m.rd = id_rd;
            m.d1 = id_rs1_data; m.d2 = id_rs2_data; m.imm = id_imm; m.src = id_alu_src;
            m.op = id_alu_op; m.mr = id_mem_read; m.mw = id_mem_write; m.rw = id_reg_write;
        end
        @(negedge clk);
        check_ex();
    endtask

    task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic src, input logic [31:0] imm,
                          input logic [3:0] op, input logic mr, input logic mw, input logic rw);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rs1_data = d1; id_rs2_data = d2;
        id_alu_src = src; id_imm = imm; id_alu_op = op; id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
    endtask

    task automatic fwd_off();
        exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
        memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
    endtask

    initial begin
        m = '0;
        cnt_m = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ex_valid", 32'(ex_valid), 0);
        chk("rst_ex_operation", 32'(ex_operation), 0);
        chk("rst_bubble_count", 32'(bubble_count), 0);
        chk("rst_load_use_stall", 32'(load_use_stall), 0);
        chk("rst_ex_rd", 32'(ex_rd), 0);
        @(negedge clk);
        reset_n = 1;
        tick();
        chk("idle_ex_valid", 32'(ex_valid), 0);

        // plain add, no forwarding
        id_set(1, 3, 4, 1, 10, 5, 0, 0, 2, 0, 0, 1);
        tick();
        chk("add_src_a", ex_src_a, 10);
        chk("add_src_b", ex_src_b, 5);
        chk("add_op", 32'(ex_operation), 2);
        chk("add_valid", 32'(ex_valid), 1);

        // forwarding priority on rs1=5
        id_set(1, 5, 6, 2, 32'h55, 32'h66, 0, 0, 3, 0, 0, 1);
        tick();
        id_valid = 0;
        exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'h11;
        memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'h22;
        check_ex();
        chk("fwd_exmem", ex_src_a, 32'h11);
        exmem_reg_write = 0;
        check_ex();
        chk("fwd_memwb", ex_src_a, 32'h22);
        exmem_reg_write = 1; exmem_rd = 0; memwb_rd = 0;
        check_ex();
        chk("fwd_x0", ex_src_a, 32'h55);
        fwd_off();

        // load-use on rs2
        id_set(1, 1, 2, 7, 0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        id_set(1, 1, 7, 8, 32'h1, 32'h0, 0, 0, 0, 0, 0, 1);
        #1 chk("lu_stall", 32'(load_use_stall), 1);
        tick();
        chk("lu_bubble_valid", 32'(ex_valid), 0);
        chk("lu_bubble_count", 32'(bubble_count), 1);
        tick();
        memwb_reg_write = 1; memwb_rd = 7; memwb_result = 32'h77;
        check_ex();
        chk("lu_replay_valid", 32'(ex_valid), 1);
        chk("lu_replay_fwd", ex_store_data, 32'h77);
        fwd_off();

        // flush together with a load-use stall counts once
        id_set(1, 1, 2, 9, 0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        id_set(1, 9, 3, 4, 0, 0, 0, 0, 1, 0, 0, 1);
        flush = 1;
        #1 chk("fl_stall", 32'(load_use_stall), 1);
        tick();
        flush = 0;
        chk("fl_valid", 32'(ex_valid), 0);
        chk("fl_reg_write", 32'(ex_reg_write), 0);
        chk("fl_count", 32'(bubble_count), 2);

        // immediate store with forwarded store data
        id_set(1, 0, 6, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 1, 0);
        tick();
        exmem_reg_write = 1; exmem_rd = 6; exmem_result = 32'hABCD;
        check_ex();
        chk("st_src_b", ex_src_b, 32'hFFFF_FFFC);
        chk("st_data", ex_store_data, 32'hABCD);
        chk("st_mem_write", 32'(ex_mem_write), 1);
        fwd_off();

        // async reset during a stall
        id_set(1, 1, 2, 10, 0, 0, 0, 0, 0, 1, 0, 1);
        tick();
        id_set(1, 10, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1);
        #1 chk("rs_stall_before", 32'(load_use_stall), 1);
        reset_n = 0;
        #1;
        chk("rs_stall_after", 32'(load_use_stall), 0);
        chk("rs_valid", 32'(ex_valid), 0);
        chk("rs_count", 32'(bubble_count), 0);
        m = '0;
        cnt_m = 0;
        @(negedge clk);
        reset_n = 1;

        // random traffic; flushes are frequent enough to reach counter saturation
        for (int i = 0; i < 400; i++) begin
            id_set($urandom_range(0, 3) != 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom), $urandom, 4'($urandom),
                   $urandom_range(0, 1) == 1, 1'($urandom), 1'($urandom));
            flush = $urandom_range(0, 5) == 0;
            exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(0, 3)); exmem_result = $urandom;
            memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(0, 3)); memwb_result = $urandom;
            tick();
        end
        chk("sat_count", 32'(bubble_count), (1 << CW) - 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage that directly feeds the EX-stage ALU (SrcA, SrcB, Operation).
- Registers decoded operands and control at the ID/EX boundary.
- Resolves data hazards with EX/MEM and MEM/WB operand forwarding, and detects load-use hazards.
- Inserts bubbles on stall or flush, and keeps a saturating bubble counter for performance debug.

Parameters:
- DATA_WIDTH, 32, operand/result width
- OPCODE_LENGTH, 4, ALU operation code width
- REG_ADDR_W, 5, register index width
- CNT_W, 16, bubble counter width

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  REG_ADDR_W  source register 1 index
- id_rs2  in  REG_ADDR_W  source register 2 index
- id_rd  in  REG_ADDR_W  destination register index
- id_rs1_data  in  DATA_WIDTH  register file read 1
- id_rs2_data  in  DATA_WIDTH  register file read 2
- id_imm  in  DATA_WIDTH  sign-extended immediate
- id_alu_src  in  1  0: SrcB = rs2 operand, 1: SrcB = imm
- id_alu_op  in  OPCODE_LENGTH  ALU operation code
- id_mem_read  in  1  instruction is a load
- id_mem_write  in  1  instruction is a store
- id_reg_write  in  1  instruction writes rd
- flush  in  1  branch/jump taken; kill the instruction entering EX
- exmem_reg_write  in  1  EX/MEM writes back
- exmem_rd  in  REG_ADDR_W  EX/MEM destination
- exmem_result  in  DATA_WIDTH  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB writes back
- memwb_rd  in  REG_ADDR_W  MEM/WB destination
- memwb_result  in  DATA_WIDTH  MEM/WB writeback value
- load_use_stall  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_src_a  out  DATA_WIDTH  ALU SrcA
- ex_src_b  out  DATA_WIDTH  ALU SrcB
- ex_operation  out  OPCODE_LENGTH  ALU Operation
- ex_store_data  out  DATA_WIDTH  forwarded rs2 value for stores
- ex_rd  out  REG_ADDR_W  destination register
- ex_reg_write  out  1  write-back enable
- ex_mem_read  out  1  load enable
- ex_mem_write  out  1  store enable
- bubble_count  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (reset_n low, async):
  - All registered fields clear to 0: ex_valid=0, ex_rd=0, ex_operation=0 (AND), all control bits 0.
  - bubble_count=0.
  - Outputs stay at these values until the first rising edge after release.
- Registered state: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, alu_src, alu_op, mem_read, mem_write, reg_write.
- Hazard detection (combinational):
  - load_use_stall = id_valid & ex_valid & ex_mem_read & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - rs2 matches even when the ID instruction uses an immediate (conservative).
- Per-edge update priority:
  - flush: bubble.
  - else load_use_stall: bubble.
  - else id_valid=0: bubble.
  - else load the ID fields.
- A bubble clears valid, reg_write, mem_read and mem_write; the data fields are don't-care.
- flush together with load_use_stall: flush wins; bubble_count increments once.
- bubble_count increments by 1 on each flush or stall bubble and saturates at 2^CNT_W-1. A plain id_valid=0 bubble does not count.
- Forwarding, applied combinationally to the registered rs1/rs2 values in the current EX cycle:
  - fwdA = exmem_result if exmem_reg_write & exmem_rd != 0 & exmem_rd == rs1_q.
  - else fwdA = memwb_result if memwb_reg_write & memwb_rd != 0 & memwb_rd == rs1_q.
  - else fwdA = rs1_data_q.
  - fwdB is identical using rs2_q.
  - EX/MEM has priority over MEM/WB. x0 is never forwarded.
- ALU operand and store outputs:
  - ex_src_a = fwdA.
  - ex_src_b = alu_src_q ? imm_q : fwdB.
  - ex_store_data = fwdB.
  - ex_operation = alu_op_q.
- Latency: one cycle from ID to the EX outputs; forwarding adds no cycles.
- When ex_valid=0, ex_src_a, ex_src_b and ex_store_data are unconstrained, but all control outputs must be 0.
- Reset asserted mid-stall clears state immediately; load_use_stall drops combinationally, since ex_valid=0.

Test Plan:
- Reset held, then released with id_valid=0 -> ex_valid=0, ex_operation=0, bubble_count=0, load_use_stall=0.
- ID add with rs1=3 (data 10), rs2=4 (data 5), alu_src=0, op=2, no matching forwards -> next cycle ex_src_a=10, ex_src_b=5, ex_operation=2, ex_valid=1.
- Forwarding priority: registered rs1=5; exmem rd=5 result 0x11; memwb rd=5 result 0x22 -> ex_src_a=0x11. Drop exmem_reg_write -> ex_src_a=0x22. Set both rd=0 -> ex_src_a=rs1_data.
- Load-use: EX holds lw with rd=7; ID instruction uses rs2=7 -> load_use_stall=1, next cycle ex_valid=0, bubble_count=1. The held instruction then loads next cycle with forwarding from MEM/WB.
- Flush together with load_use_stall -> next cycle ex_valid=0, ex_reg_write=0, bubble_count increments by exactly 1.
- Immediate path with store: alu_src=1, imm=0xFFFFFFFC, mem_write=1, rs2 forwarded from exmem (0xABCD) -> ex_src_b=0xFFFFFFFC, ex_store_data=0xABCD, ex_mem_write=1.
